// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data memory controller for byte/half/word
// loads and stores over an internal word-wide RAM.
//   clk, rst       : clock, synchronous active-high reset
//   req_valid/ready: request handshake (ready only while idle)
//   req_we         : 1 = store, 0 = load
//   req_size       : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned   : zero-extend loads when 1, sign-extend when 0
//   req_addr       : byte address; word index = req_addr[31:2]
//   req_wdata      : right-aligned store data
//   rsp_valid      : one-cycle response pulse
//   rsp_rdata      : extended load data (0 for stores and errors)
//   rsp_err        : misaligned, out-of-range or illegal-size request
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    lane_q, lane_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   mem_rdata_q;
  logic [31:0]   merged;
  logic [31:0]   load_ext;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic          req_err;

  // Range check uses the full word index so high addresses never alias.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                           req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0])            req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= DEPTH_WORDS)      req_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          err_d   = req_err;
          state_d = req_err ? RESP : RD;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      lane_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // RAM port: read in RD, write in WR. Contents survive reset; a reset
  // coinciding with the WR edge cancels the write.
  always_ff @(posedge clk) begin
    if (state_q == RD) mem_rdata_q <= mem[idx_q];
    if (state_q == WR && !rst) mem[idx_q] <= merged;
  end

  // Read-modify-write merge of store data into the addressed lane(s).
  always_comb begin
    merged = mem_rdata_q;
    case (size_q)
      2'b00: begin
        case (lane_q)
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (lane_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    load_byte = mem_rdata_q[7:0];
      2'd1:    load_byte = mem_rdata_q[15:8];
      2'd2:    load_byte = mem_rdata_q[23:16];
      default: load_byte = mem_rdata_q[31:24];
    endcase
    load_half = lane_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{load_byte[7] & ~uns_q}}, load_byte};
      2'b01:   load_ext = {{16{load_half[15] & ~uns_q}}, load_half};
      default: load_ext = mem_rdata_q;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? load_ext : '0;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words in internal RAM (word address = req_addr[31:2]).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  load/store request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  load zero-extends when 1 (lbu/lhu), sign-extends when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse, response present.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  request was misaligned, out of range, or illegal size.

Function
REQ-014 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request when req_valid && req_ready; latch we, size, unsigned, addr, wdata in that cycle; inputs ignored outside IDLE.
REQ-016 SHALL flag error at acceptance when: size=11; size=01 and addr[0]=1; size=10 and addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS.
REQ-017 SHALL, on error, go IDLE->RESP with no RAM read or write; rsp_valid asserted the cycle after acceptance with rsp_err=1, rsp_rdata=0.
REQ-018 SHALL, on a legal load, go IDLE->RD->RESP; RD issues synchronous RAM read; rsp_valid 2 cycles after acceptance.
REQ-019 SHALL extract load byte from lane addr[1:0] (00 [7:0], 01 [15:8], 10 [23:16], 11 [31:24]) and half from addr[1] (0 [15:0], 1 [31:16]).
REQ-020 SHALL sign-extend from bit 7/15 when req_unsigned=0, zero-extend when 1; word loads ignore req_unsigned.
REQ-021 SHALL, on a legal store, go IDLE->RD->WR->RESP (read-modify-write for all sizes); RAM write on the WR edge; rsp_valid 3 cycles after acceptance, rsp_rdata=0.
REQ-022 SHALL merge store data into only the addressed lane(s) using the lane rules of REQ-019; unaddressed bytes retain prior value.
REQ-023 SHALL return RESP->IDLE unconditionally after one cycle; no response backpressure; rsp_valid and rsp_err low in every non-RESP cycle.
REQ-024 SHALL allow back-to-back requests: a request presented in the cycle after RESP is accepted (IDLE), minimum spacing 2/3/4 cycles for error/load/store.
REQ-025 SHALL make a load following a store to the same word return the post-store value (write completes before next acceptance).
REQ-026 SHALL compute the word index from addr[31:2] without wrap; addresses beyond DEPTH_WORDS are errors, never aliased.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set state IDLE, req_ready=1 after that edge, rsp_valid=0, rsp_rdata=0, rsp_err=0, clear latched request fields.
REQ-028 SHALL, if rst=1 at the WR edge, suppress the RAM write (reset wins); if reset during RD, abandon with no response.
REQ-029 SHALL NOT clear RAM contents on reset.
REQ-030 SHALL give rst priority over req_valid in the same cycle (request not accepted).

Verification
REQ-031 SHALL pass: sw 0xDEADBEEF @0x10, then lw @0x10 -> store rsp 3 cycles after accept, rsp_err=0; load rsp 2 cycles after accept, rsp_rdata=0xDEADBEEF.
REQ-032 SHALL pass: after REQ-031, sb 0x5A @0x12 then lw @0x10 -> 0xDE5ABEEF; lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE.
REQ-033 SHALL pass: sh 0x8001 @0x22 over word 0 -> word 0x80010000; lh @0x22 -> 0xFFFF8001; lhu @0x22 -> 0x00008001.
REQ-034 SHALL pass: lw @0x11, sh @0x13, size=11 @0x0, lw @0x400 (DEPTH 256) -> each rsp_valid 1 cycle after accept, rsp_err=1, rsp_rdata=0, RAM unchanged.
REQ-035 SHALL pass: sw 0x12345678 @0x8 with rst pulsed during the WR cycle -> no rsp_valid, req_ready=1 next cycle, later lw @0x8 returns prior contents.
REQ-036 SHALL pass: req_valid held high continuously with alternating sw/lw to @0x4 -> acceptances only in IDLE, each load returns the immediately preceding store's data.
